core: RTL and testbench
=======================

# core

Minimal 4-bit microcontroller core (E0C6S46-style) executing the program-flow subset: CALL, CALZ, JP, RET, PSET and NOP5. It fetches 12-bit instructions from program ROM, keeps the PC and stack in 4-bit data RAM, and sits between the ROM and the RAM/IO bus. It is the execution engine that unit benches drive one instruction at a time.

## Interface
- No parameters.
- `clk`  in  1  core clock; one instruction clock per cycle.
- `reset`  in  1  synchronous, active-high.
- `rom_addr`  out  13  PC driving program ROM.
- `rom_data`  in  12  instruction word at `rom_addr`; combinational read.
- `ram_addr`  out  12  data memory address.
- `ram_wdata`  out  4  write nibble.
- `ram_we`  out  1  write strobe, one cycle per nibble.
- `ram_rdata`  in  4  read nibble for `ram_addr`; combinational.
- `fetch`  out  1  pulses in the final stage, when the PC holds the next fetch address.
- `instr_done`  out  1  pulses in the last cycle of each instruction.
- `pc`  out  13  {bank[12], page[11:8], step[7:0]}.
- `np`  out  5  {NBP, NPP[3:0]}.
- `sp`  out  8  stack pointer.

## Operation
- Reset values: PC=0x0100, NP=0x01, SP=0x44, A=B=0, X=Y=0. Outputs `ram_we`, `fetch` and `instr_done` are 0. The FSM starts a new instruction in the next cycle.
- Decode on `rom_data` latched in cycle 0:
  - 0x4ss CALL s: push, then PC = {PC.bank, NPP, s}. The bank is unchanged and NBP is ignored.
  - 0x5ss CALZ s: push, then PC = {PC.bank, 0x0, s}.
  - 0x0ss JP s: PC = {PC.bank, NPP, s}.
  - 0xFDF RET: pop PC[11:0]; the bank is unchanged.
  - 0xE4p PSET p: NP = p[4:0].
  - 0xFFB NOP5, and every undecoded word, executes as NOP5.
- Return address: R = PC[11:0] + 1. It is a 12-bit add with carry across step into page and wrap at 0xFFF; the bank is never touched.
- Push order, SP decrementing: M[SP-1]=R[11:8] (PCP), M[SP-2]=R[7:4] (PCSH), M[SP-3]=R[3:0] (PCSL). Then SP -= 3, wrapping mod 256.
- Pop: PCSL=M[SP], PCSH=M[SP+1], PCP=M[SP+2]. Then SP += 3.
- JP, NOP5 and PSET with no jump advance PC by the same 12-bit +1.
- After any instruction other than PSET, NP = {new PC.bank, new PC.page}. After PSET, NP holds p for exactly the next instruction.
- A, B, X and Y are never modified by this subset.

## Timing
- Lengths: CALL, CALZ and RET take 7 cycles. JP, PSET and NOP5 take 5 cycles.
- CALL/CALZ, stage counter 0..6:
  - 0: latch opcode.
  - 1–3: RAM writes of PCP, PCSH, PCSL.
  - 4: SP update.
  - 5: PC ← target and `fetch`=1.
  - 6: NP update and `instr_done`=1.
- RET:
  - 1–3: reads at SP, SP+1, SP+2.
  - 4: SP update.
  - 5: PC load and `fetch`.
  - 6: `instr_done`.
- 5-cycle instructions: PC and NP update in stage 3 with `fetch`. `instr_done` is in stage 4.
- The next opcode is latched in the cycle after `instr_done`.
- Reset mid-instruction aborts the instruction. State returns to reset values, and partial RAM writes remain.

## Structure
- Shared package `core_pkg`:
  - opcode constants and masks (CALL, CALZ, JP, RET, PSET, NOP5);
  - the stage enum/width;
  - reset constants PC, NP and SP.
- Optional sub-module `core_regs`: the register file (PC, NP, SP, A, B, X, Y) with load enables. The control FSM lives in `core`.

## Test plan
- CALL 0x4AB, PC=0x1234, NP=0x12, SP=0x44:
  - PC=0x12AB at `fetch`; 7 cycles; SP=0x41.
  - M[0x43]=2, M[0x42]=3, M[0x41]=5.
- CALL 0x444, PC=0x1234, NP=0x0A: PC=0x1A44 (bank kept, NBP ignored), SP=0x41, 7 cycles.
- CALZ 0x569, PC=0x1ABC, NP=0x15: PC=0x1069; M[0x43]=A, M[0x42]=B, M[0x41]=D.
- CALL 0x4AB, PC=0x05FF, NP=0x03:
  - PC=0x03AB; M[0x43]=6, M[0x42]=0, M[0x41]=0.
  - CALZ 0x5AB from the same state gives PC=0x00AB with identical stack contents.
- RET after the first scenario: PC=0x1235, SP=0x44, 7 cycles, NP=0x12.
- PSET 0xE45 then JP 0x010 from PC=0x0100: PC=0x0510, 5 cycles each, NP=0x05 afterwards. A, B, X and Y are unchanged in every scenario.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the program-flow core: opcodes, stage numbering and
// reset values of the architectural registers.
package core_pkg;

    localparam logic [12:0] PC_RESET = 13'h0100;
    localparam logic [4:0]  NP_RESET = 5'h01;
    localparam logic [7:0]  SP_RESET = 8'h44;

    localparam logic [11:0] OPC_CALL  = 12'h400;
    localparam logic [11:0] MASK_CALL = 12'hF00;
    localparam logic [11:0] OPC_CALZ  = 12'h500;
    localparam logic [11:0] MASK_CALZ = 12'hF00;
    localparam logic [11:0] OPC_JP    = 12'h000;
    localparam logic [11:0] MASK_JP   = 12'hF00;
    localparam logic [11:0] OPC_RET   = 12'hFDF;
    localparam logic [11:0] MASK_RET  = 12'hFFF;
    localparam logic [11:0] OPC_PSET  = 12'hE40;
    localparam logic [11:0] MASK_PSET = 12'hFE0;
    localparam logic [11:0] OPC_NOP5  = 12'hFFB;
    localparam logic [11:0] MASK_NOP5 = 12'hFFF;

    typedef enum logic [2:0] {
        OP_NOP5,
        OP_JP,
        OP_CALL,
        OP_CALZ,
        OP_RET,
        OP_PSET
    } op_e;

    localparam int STAGE_W = 3;
    typedef logic [STAGE_W-1:0] stage_t;
    localparam stage_t STAGE_OPCODE = 3'd0;
    localparam stage_t LAST_SHORT   = 3'd4;
    localparam stage_t LAST_LONG    = 3'd6;

    // Anything outside the subset falls through to NOP5.
    function automatic op_e decode_op(input logic [11:0] w);
        op_e op;
        if ((w & MASK_RET) == OPC_RET)        op = OP_RET;
        else if ((w & MASK_NOP5) == OPC_NOP5) op = OP_NOP5;
        else if ((w & MASK_PSET) == OPC_PSET) op = OP_PSET;
        else if ((w & MASK_CALL) == OPC_CALL) op = OP_CALL;
        else if ((w & MASK_CALZ) == OPC_CALZ) op = OP_CALZ;
        else if ((w & MASK_JP) == OPC_JP)     op = OP_JP;
        else                                  op = OP_NOP5;
        return op;
    endfunction

endpackage

// File: rtl/core_regs.sv
// Architectural register file: PC, NP and SP with load enables, plus the
// A/B/X/Y data registers that the program-flow subset never writes.
module core_regs
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_we,
    input  logic [12:0] pc_wdata,
    input  logic        np_we,
    input  logic [4:0]  np_wdata,
    input  logic        sp_we,
    input  logic [7:0]  sp_wdata,
    output logic [12:0] pc,
    output logic [4:0]  np,
    output logic [7:0]  sp
);

    logic [12:0] pc_q, pc_d;
    logic [4:0]  np_q, np_d;
    logic [7:0]  sp_q, sp_d;
    logic [3:0]  a_q, a_d, b_q, b_d;
    logic [11:0] x_q, x_d, y_q, y_d;

    always_comb begin
        pc_d = pc_we ? pc_wdata : pc_q;
        np_d = np_we ? np_wdata : np_q;
        sp_d = sp_we ? sp_wdata : sp_q;
        a_d  = a_q;
        b_d  = b_q;
        x_d  = x_q;
        y_d  = y_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= PC_RESET;
            np_q <= NP_RESET;
            sp_q <= SP_RESET;
            a_q  <= 4'h0;
            b_q  <= 4'h0;
            x_q  <= 12'h000;
            y_q  <= 12'h000;
        end else begin
            pc_q <= pc_d;
            np_q <= np_d;
            sp_q <= sp_d;
            a_q  <= a_d;
            b_q  <= b_d;
            x_q  <= x_d;
            y_q  <= y_d;
        end
    end

    assign pc = pc_q;
    assign np = np_q;
    assign sp = sp_q;

    // Data registers stay at reset until data-path instructions are added.
    logic unused_regs;
    assign unused_regs = ^{a_q, b_q, x_q, y_q};

endmodule

// File: rtl/core.sv
// Program-flow execution engine: a stage counter sequences CALL/CALZ/RET over
// seven cycles and JP/PSET/NOP5 over five, driving ROM and RAM buses.
module core
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [12:0] rom_addr,
    input  logic [11:0] rom_data,
    output logic [11:0] ram_addr,
    output logic [3:0]  ram_wdata,
    output logic        ram_we,
    input  logic [3:0]  ram_rdata,
    output logic        fetch,
    output logic        instr_done,
    output logic [12:0] pc,
    output logic [4:0]  np,
    output logic [7:0]  sp
);

    stage_t      stage_q, stage_d, last_stage;
    op_e         op_q, op_d, op_cur;
    logic [7:0]  imm_q, imm_d, imm_cur;
    logic [3:0]  pcsl_q, pcsl_d, pcsh_q, pcsh_d, pcp_q, pcp_d;
    logic [11:0] ram_addr_q, ram_addr_d;
    logic [3:0]  ram_wdata_q, ram_wdata_d;
    logic        ram_we_q, ram_we_d;
    logic        fetch_q, fetch_d;
    logic        done_q, done_d;
    logic        is_long;
    logic [11:0] ret_addr;
    logic        pc_we, np_we, sp_we;
    logic [12:0] pc_wdata;
    logic [4:0]  np_wdata;
    logic [7:0]  sp_wdata;

    core_regs u_regs (
        .clk      (clk),
        .reset    (reset),
        .pc_we    (pc_we),
        .pc_wdata (pc_wdata),
        .np_we    (np_we),
        .np_wdata (np_wdata),
        .sp_we    (sp_we),
        .sp_wdata (sp_wdata),
        .pc       (pc),
        .np       (np),
        .sp       (sp)
    );

    // Outputs are registered, so each action is keyed on the stage being entered.
    always_comb begin
        op_cur      = (stage_q == STAGE_OPCODE) ? decode_op(rom_data) : op_q;
        imm_cur     = (stage_q == STAGE_OPCODE) ? rom_data[7:0] : imm_q;
        is_long     = (op_cur == OP_CALL) || (op_cur == OP_CALZ) || (op_cur == OP_RET);
        last_stage  = is_long ? LAST_LONG : LAST_SHORT;
        stage_d     = (stage_q == last_stage) ? STAGE_OPCODE : stage_t'(stage_q + 3'd1);
        op_d        = op_cur;
        imm_d       = imm_cur;
        ret_addr    = pc[11:0] + 12'd1;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = 4'h0;
        ram_we_d    = 1'b0;
        fetch_d     = 1'b0;
        done_d      = 1'b0;
        pc_we       = 1'b0;
        pc_wdata    = pc;
        np_we       = 1'b0;
        np_wdata    = np;
        sp_we       = 1'b0;
        sp_wdata    = sp;
        pcsl_d      = pcsl_q;
        pcsh_d      = pcsh_q;
        pcp_d       = pcp_q;

        if (is_long) begin
            case (stage_d)
                3'd1, 3'd2, 3'd3: begin
                    if (op_cur == OP_RET) begin
                        ram_addr_d = {4'h0, sp + 8'(stage_d) - 8'd1};
                    end else begin
                        ram_we_d   = 1'b1;
                        ram_addr_d = {4'h0, sp - 8'(stage_d)};
                        case (stage_d)
                            3'd1:    ram_wdata_d = ret_addr[11:8];
                            3'd2:    ram_wdata_d = ret_addr[7:4];
                            default: ram_wdata_d = ret_addr[3:0];
                        endcase
                    end
                end
                3'd4: begin
                    sp_we    = 1'b1;
                    sp_wdata = (op_cur == OP_RET) ? sp + 8'd3 : sp - 8'd3;
                end
                3'd5: begin
                    pc_we   = 1'b1;
                    fetch_d = 1'b1;
                    case (op_cur)
                        OP_CALL: pc_wdata = {pc[12], np[3:0], imm_cur};
                        OP_CALZ: pc_wdata = {pc[12], 4'h0, imm_cur};
                        default: pc_wdata = {pc[12], pcp_q, pcsh_q, pcsl_q};
                    endcase
                end
                3'd6: begin
                    np_we    = 1'b1;
                    np_wdata = {pc[12], pc[11:8]};
                    done_d   = 1'b1;
                end
                default: ;
            endcase

            if (op_cur == OP_RET) begin
                case (stage_q)
                    3'd1:    pcsl_d = ram_rdata;
                    3'd2:    pcsh_d = ram_rdata;
                    3'd3:    pcp_d  = ram_rdata;
                    default: ;
                endcase
            end
        end else begin
            case (stage_d)
                3'd3: begin
                    pc_we    = 1'b1;
                    fetch_d  = 1'b1;
                    pc_wdata = (op_cur == OP_JP) ? {pc[12], np[3:0], imm_cur}
                                                 : {pc[12], ret_addr};
                    np_we    = 1'b1;
                    // PSET's page pointer survives only into the next instruction.
                    np_wdata = (op_cur == OP_PSET) ? imm_cur[4:0]
                                                   : {pc_wdata[12], pc_wdata[11:8]};
                end
                3'd4:    done_d = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q     <= STAGE_OPCODE;
            op_q        <= OP_NOP5;
            imm_q       <= 8'h00;
            pcsl_q      <= 4'h0;
            pcsh_q      <= 4'h0;
            pcp_q       <= 4'h0;
            ram_addr_q  <= 12'h000;
            ram_wdata_q <= 4'h0;
            ram_we_q    <= 1'b0;
            fetch_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            stage_q     <= stage_d;
            op_q        <= op_d;
            imm_q       <= imm_d;
            pcsl_q      <= pcsl_d;
            pcsh_q      <= pcsh_d;
            pcp_q       <= pcp_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
            fetch_q     <= fetch_d;
            done_q      <= done_d;
        end
    end

    assign rom_addr   = pc;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign ram_we     = ram_we_q;
    assign fetch      = fetch_q;
    assign instr_done = done_q;

endmodule

// File: tb/tb_core.sv
// Directed bench for core: one instruction at a time with hand-computed PC,
// NP, SP, instruction length and RAM write sequence.
module tb_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [12:0] rom_addr;
    logic [11:0] rom_word = 12'hFFB;
    logic [11:0] ram_addr;
    logic [3:0]  ram_wdata;
    logic        ram_we;
    logic [3:0]  ram_rdata;
    logic        fetch;
    logic        instr_done;
    logic [12:0] pc;
    logic [4:0]  np;
    logic [7:0]  sp;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0]  mem [0:4095];
    logic [15:0] wr_log [0:63];
    int          wr_cnt = 0;

    always #5 clk = ~clk;

    core dut (
        .clk        (clk),
        .reset      (reset),
        .rom_addr   (rom_addr),
        .rom_data   (rom_word),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we),
        .ram_rdata  (ram_rdata),
        .fetch      (fetch),
        .instr_done (instr_done),
        .pc         (pc),
        .np         (np),
        .sp         (sp)
    );

    assign ram_rdata = mem[ram_addr];

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            if (wr_cnt < 64) wr_log[wr_cnt] <= {ram_addr, ram_wdata};
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called in the opcode cycle; returns in the opcode cycle of the next instruction.
    task automatic run_instr(input string tag, input logic [11:0] word, input int exp_len,
                             input logic [12:0] exp_pc, input logic [4:0] exp_np,
                             input logic [7:0] exp_sp, input int exp_nw,
                             input logic [47:0] exp_w);
        int          base;
        int          fetch_cyc;
        int          done_cyc;
        logic [12:0] fetch_pc;
        logic [47:0] w;
        base      = wr_cnt;
        rom_word  = word;
        fetch_cyc = 0;
        done_cyc  = 0;
        fetch_pc  = 13'h0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (fetch) begin
                fetch_cyc = c;
                fetch_pc  = rom_addr;
            end
            if (instr_done) begin
                done_cyc = c;
                break;
            end
        end
        check({tag, ".len"}, 16'(done_cyc + 1), 16'(exp_len));
        check({tag, ".fetch_stage"}, 16'(fetch_cyc), 16'(exp_len - 2));
        check({tag, ".fetch_pc"}, 16'(fetch_pc), 16'(exp_pc));
        check({tag, ".pc"}, 16'(pc), 16'(exp_pc));
        check({tag, ".np"}, 16'(np), 16'(exp_np));
        check({tag, ".sp"}, 16'(sp), 16'(exp_sp));
        check({tag, ".nwrites"}, 16'(wr_cnt - base), 16'(exp_nw));
        w = exp_w;
        for (int i = 0; i < exp_nw; i++) begin
            check({tag, ".write"}, wr_log[base + i], w[47:32]);
            w = w << 16;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset.pc", 16'(pc), 16'h0100);
        check("reset.np", 16'(np), 16'h0001);
        check("reset.sp", 16'(sp), 16'h0044);
        check("reset.ram_we", 16'(ram_we), 16'h0);
        check("reset.fetch", 16'(fetch), 16'h0);
        check("reset.done", 16'(instr_done), 16'h0);
        reset = 1'b0;

        run_instr("pset02",  12'hE42, 5, 13'h0101, 5'h02, 8'h44, 0, 48'h0);
        run_instr("jp33",    12'h033, 5, 13'h0233, 5'h02, 8'h44, 0, 48'h0);
        run_instr("pset12",  12'hE52, 5, 13'h0234, 5'h12, 8'h44, 0, 48'h0);
        run_instr("call4ab", 12'h4AB, 7, 13'h02AB, 5'h02, 8'h41, 3, {16'h0432, 16'h0423, 16'h0415});
        run_instr("ret1",    12'hFDF, 7, 13'h0235, 5'h02, 8'h44, 0, 48'h0);

        run_instr("pset0a",  12'hE4A, 5, 13'h0236, 5'h0A, 8'h44, 0, 48'h0);
        run_instr("call444", 12'h444, 7, 13'h0A44, 5'h0A, 8'h41, 3, {16'h0432, 16'h0423, 16'h0417});
        run_instr("ret2",    12'hFDF, 7, 13'h0237, 5'h02, 8'h44, 0, 48'h0);

        run_instr("pset0a_b", 12'hE4A, 5, 13'h0238, 5'h0A, 8'h44, 0, 48'h0);
        run_instr("jpbb",     12'h0BB, 5, 13'h0ABB, 5'h0A, 8'h44, 0, 48'h0);
        run_instr("pset15",   12'hE55, 5, 13'h0ABC, 5'h15, 8'h44, 0, 48'h0);
        run_instr("calz569",  12'h569, 7, 13'h0069, 5'h00, 8'h41, 3, {16'h043A, 16'h042B, 16'h041D});
        run_instr("ret3",     12'hFDF, 7, 13'h0ABD, 5'h0A, 8'h44, 0, 48'h0);

        run_instr("pset05",   12'hE45, 5, 13'h0ABE, 5'h05, 8'h44, 0, 48'h0);
        run_instr("jpfe",     12'h0FE, 5, 13'h05FE, 5'h05, 8'h44, 0, 48'h0);
        run_instr("pset03",   12'hE43, 5, 13'h05FF, 5'h03, 8'h44, 0, 48'h0);
        run_instr("call_cy",  12'h4AB, 7, 13'h03AB, 5'h03, 8'h41, 3, {16'h0436, 16'h0420, 16'h0410});
        run_instr("ret4",     12'hFDF, 7, 13'h0600, 5'h06, 8'h44, 0, 48'h0);

        run_instr("pset05_b", 12'hE45, 5, 13'h0601, 5'h05, 8'h44, 0, 48'h0);
        run_instr("jpfe_b",   12'h0FE, 5, 13'h05FE, 5'h05, 8'h44, 0, 48'h0);
        run_instr("pset03_b", 12'hE43, 5, 13'h05FF, 5'h03, 8'h44, 0, 48'h0);
        run_instr("calz_cy",  12'h5AB, 7, 13'h00AB, 5'h00, 8'h41, 3, {16'h0436, 16'h0420, 16'h0410});
        run_instr("ret5",     12'hFDF, 7, 13'h0600, 5'h06, 8'h44, 0, 48'h0);

        run_instr("nop5",     12'hFFB, 5, 13'h0601, 5'h06, 8'h44, 0, 48'h0);
        run_instr("undef",    12'h123, 5, 13'h0602, 5'h06, 8'h44, 0, 48'h0);

        // Abort a CALL after two of its pushes have gone out.
        rom_word = 12'h4AB;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort.pc", 16'(pc), 16'h0100);
        check("abort.np", 16'(np), 16'h0001);
        check("abort.sp", 16'(sp), 16'h0044);
        check("abort.ram_we", 16'(ram_we), 16'h0);
        check("abort.fetch", 16'(fetch), 16'h0);
        check("abort.done", 16'(instr_done), 16'h0);
        run_instr("pset01", 12'hE41, 5, 13'h0101, 5'h01, 8'h44, 0, 48'h0);

        check("regs.a", 16'(dut.u_regs.a_q), 16'h0);
        check("regs.b", 16'(dut.u_regs.b_q), 16'h0);
        check("regs.x", 16'(dut.u_regs.x_q), 16'h0);
        check("regs.y", 16'(dut.u_regs.y_q), 16'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
